gate_resp_checker: RTL and testbench

- Hardware response checker for a two-input combinational gate under test. It is the receiving/checking end of a stimulus stream: a driver applies (a, b) vectors and the gate produces c; this block samples each triple.
- Each sample is compared against a programmable 4-entry truth table. The block counts samples and mismatches, records the first failure, and reports pass/fail when the run ends.
- Used in on-chip self-test wrappers and as a synthesizable scoreboard in benches.

---
 rtl/gate_resp_checker.sv | 129 ++++++++++++
 tb/tb_gate_resp_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: samples (a,b,c) triples of a two-input gate, checks them against a
// latched 4-entry truth table, and reports counts, first failure and pass/fail per run.
`default_nettype none

module gate_resp_checker #(
   parameter int unsigned MAX_SAMPLES = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [3:0]       truth_i,
   input  logic             valid_i,
   input  logic             a_i,
   input  logic             b_i,
   input  logic             c_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             err_o,
   output logic [CNT_W-1:0] sample_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] first_fail_idx_o,
   output logic [2:0]       first_fail_vec_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [3:0]       truth_q;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] ff_idx;
   logic [2:0]       ff_vec;
   logic             ff_seen;
   logic             err_q;

   logic             start_acc;
   logic             accept;
   logic             expected;
   logic             mismatch;
   logic [31:0]      samp_inc;
   logic             last_sample;

   assign start_acc = start_i && ((state == S_IDLE) || (state == S_DONE));
   assign accept    = (state == S_RUN) && valid_i;
   assign expected  = truth_q[{a_i, b_i}];
   assign mismatch  = accept && (c_i != expected);
   assign samp_inc  = 32'(sample_cnt) + 32'd1;

   // The edge that accepts sample number MAX_SAMPLES also ends the run.
   assign last_sample = (MAX_SAMPLES != 0) && accept && (samp_inc == MAX_SAMPLES);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_i) state_nxt = S_RUN;
         S_RUN:   if (stop_i || last_sample) state_nxt = S_DONE;
         S_DONE:  if (start_i) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state == S_RUN);
      done_o = (state == S_DONE);
      pass_o = (state == S_DONE) && (err_cnt == '0) && (sample_cnt != '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         truth_q    <= 4'b0000;
         sample_cnt <= '0;
         err_cnt    <= '0;
         ff_idx     <= '0;
         ff_vec     <= 3'b000;
         ff_seen    <= 1'b0;
      end else if (start_acc) begin
         truth_q    <= truth_i;
         sample_cnt <= '0;
         err_cnt    <= '0;
         ff_idx     <= '0;
         ff_vec     <= 3'b000;
         ff_seen    <= 1'b0;
      end else if (accept) begin
         if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
         if (mismatch) begin
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
            // Only the first mismatch of a run is recorded.
            if (!ff_seen) begin
               ff_seen <= 1'b1;
               ff_idx  <= sample_cnt;
               ff_vec  <= {a_i, b_i, c_i};
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= mismatch;
      end
   end

   assign err_o            = err_q;
   assign sample_cnt_o     = sample_cnt;
   assign err_cnt_o        = err_cnt;
   assign first_fail_idx_o = ff_idx;
   assign first_fail_vec_o = ff_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: table of runs on the default instance with an err_o scoreboard,
// plus hand-written sequences for early stop, saturation and asynchronous reset.
`default_nettype none

module tb_gate_resp_checker;

   logic       clk;
   logic       rst_n;
   logic [3:0] truth;
   logic       valid, a, b, c;
   logic       start4, stop4, start0, stop0, start_s, stop_s;

   logic       busy4, done4, pass4, err4;
   logic [7:0] scnt4, ecnt4, fidx4;
   logic [2:0] fvec4;
   logic       busy0, done0, pass0, err0;
   logic [7:0] scnt0, ecnt0, fidx0;
   logic [2:0] fvec0;
   logic       busys, dones, passs, errs;
   logic [1:0] scnts, ecnts, fidxs;
   logic [2:0] fvecs;

   gate_resp_checker dut4 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .stop_i(stop4), .truth_i(truth),
      .valid_i(valid), .a_i(a), .b_i(b), .c_i(c),
      .busy_o(busy4), .done_o(done4), .pass_o(pass4), .err_o(err4),
      .sample_cnt_o(scnt4), .err_cnt_o(ecnt4), .first_fail_idx_o(fidx4), .first_fail_vec_o(fvec4)
   );

   gate_resp_checker #(.MAX_SAMPLES(0), .CNT_W(8)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .stop_i(stop0), .truth_i(truth),
      .valid_i(valid), .a_i(a), .b_i(b), .c_i(c),
      .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_o(err0),
      .sample_cnt_o(scnt0), .err_cnt_o(ecnt0), .first_fail_idx_o(fidx0), .first_fail_vec_o(fvec0)
   );

   gate_resp_checker #(.MAX_SAMPLES(0), .CNT_W(2)) duts (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .stop_i(stop_s), .truth_i(truth),
      .valid_i(valid), .a_i(a), .b_i(b), .c_i(c),
      .busy_o(busys), .done_o(dones), .pass_o(passs), .err_o(errs),
      .sample_cnt_o(scnts), .err_cnt_o(ecnts), .first_fail_idx_o(fidxs), .first_fail_vec_o(fvecs)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of the default instance (MAX_SAMPLES=4).
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
   int         mstate = M_IDLE;
   logic [3:0] mtruth = 4'b0000;
   int         mcnt = 0;

   typedef struct {
      int   due;
      logic exp;
   } sb_t;
   sb_t sbq[$];
   sb_t mon_e;

   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         mon_e = sbq.pop_front();
         check("err_o", int'(err4), int'(mon_e.exp));
      end else if (err4) begin
         check("err_o_spurious", int'(err4), 0);
      end
   end

   task automatic start4_run(input logic [3:0] t);
      truth  = t;
      start4 = 1'b1;
      if (mstate != M_RUN) begin
         mstate = M_RUN;
         mtruth = t;
         mcnt   = 0;
      end
      tick();
      start4 = 1'b0;
   endtask

   task automatic send(input logic [2:0] v);
      logic mis;
      {a, b, c} = v;
      valid     = 1'b1;
      if (mstate == M_RUN) begin
         mis = (v[0] != mtruth[v[2:1]]);
         sbq.push_back('{cyc + 1, mis});
         mcnt++;
         if (mcnt == 4) mstate = M_DONE;
      end
      tick();
      valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  truth;
      logic [11:0] vecs;
      int          exp_err;
      int          exp_idx;
      logic [2:0]  exp_vec;
      logic        exp_pass;
   } run_t;
   run_t runs[4];

   initial begin
      runs[0] = '{4'b1000, {3'b100, 3'b010, 3'b111, 3'b000}, 0, 0, 3'b000, 1'b1};
      runs[1] = '{4'b1000, {3'b000, 3'b110, 3'b011, 3'b100}, 2, 1, 3'b110, 1'b0};
      runs[2] = '{4'b1110, {3'b000, 3'b011, 3'b101, 3'b111}, 0, 0, 3'b000, 1'b1};
      runs[3] = '{4'b0110, {3'b111, 3'b000, 3'b100, 3'b011}, 2, 0, 3'b111, 1'b0};

      truth = 4'b0000; valid = 0; a = 0; b = 0; c = 0;
      start4 = 0; stop4 = 0; start0 = 0; stop0 = 0; start_s = 0; stop_s = 0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      check("rst_busy", int'(busy4), 0);
      check("rst_done", int'(done4), 0);
      check("rst_pass", int'(pass4), 0);
      check("rst_scnt", int'(scnt4), 0);
      check("rst_ecnt", int'(ecnt4), 0);
      check("rst_fvec", int'(fvec4), 0);

      send(3'b111);
      check("idle_valid_ignored", int'(scnt4), 0);

      for (int i = 0; i < 4; i++) begin
         start4_run(runs[i].truth);
         check("run_busy", int'(busy4), 1);
         for (int j = 0; j < 4; j++) send(runs[i].vecs[11 - 3*j -: 3]);
         check("run_done", int'(done4), 1);
         check("run_not_busy", int'(busy4), 0);
         check("run_scnt", int'(scnt4), 4);
         check("run_ecnt", int'(ecnt4), runs[i].exp_err);
         check("run_fidx", int'(fidx4), runs[i].exp_idx);
         check("run_fvec", int'(fvec4), int'(runs[i].exp_vec));
         check("run_pass", int'(pass4), int'(runs[i].exp_pass));
      end

      // valid in DONE, then start mid-run with a different table.
      send(3'b110);
      check("done_valid_scnt", int'(scnt4), 4);
      check("done_valid_ecnt", int'(ecnt4), 2);
      start4_run(4'b1000);
      send(3'b111);
      start4_run(4'b0000);
      check("midrun_start_scnt", int'(scnt4), 1);
      send(3'b111);
      send(3'b000);
      send(3'b010);
      check("ign_done", int'(done4), 1);
      check("ign_scnt", int'(scnt4), 4);
      check("ign_ecnt", int'(ecnt4), 0);
      check("ign_pass", int'(pass4), 1);

      // Unlimited run: stop together with a third, mismatching sample.
      truth = 4'b0110;
      start0 = 1'b1; tick(); start0 = 1'b0;
      send(3'b011);
      send(3'b101);
      {a, b, c} = 3'b111; valid = 1'b1; stop0 = 1'b1;
      tick();
      valid = 1'b0; stop0 = 1'b0;
      check("stop_done", int'(done0), 1);
      check("stop_busy", int'(busy0), 0);
      check("stop_scnt", int'(scnt0), 3);
      check("stop_ecnt", int'(ecnt0), 1);
      check("stop_fidx", int'(fidx0), 2);
      check("stop_fvec", int'(fvec0), 7);
      check("stop_pass", int'(pass0), 0);
      check("stop_err_pulse", int'(err0), 1);
      start0 = 1'b1; tick(); start0 = 1'b0;
      stop0 = 1'b1; tick(); stop0 = 1'b0;
      check("empty_done", int'(done0), 1);
      check("empty_scnt", int'(scnt0), 0);
      check("empty_pass", int'(pass0), 0);

      // Saturation with 2-bit counters.
      truth = 4'b0000;
      start_s = 1'b1; tick(); start_s = 1'b0;
      repeat (6) send(3'b001);
      stop_s = 1'b1; tick(); stop_s = 1'b0;
      check("sat_done", int'(dones), 1);
      check("sat_scnt", int'(scnts), 3);
      check("sat_ecnt", int'(ecnts), 3);
      check("sat_fidx", int'(fidxs), 0);
      check("sat_fvec", int'(fvecs), 1);
      check("sat_pass", int'(passs), 0);

      // Asynchronous reset in the middle of a run.
      start4_run(4'b1000);
      send(3'b110);
      send(3'b000);
      check("pre_rst_scnt", int'(scnt4), 2);
      #2 rst_n = 1'b0;
      mstate = M_IDLE;
      #1;
      check("arst_busy", int'(busy4), 0);
      check("arst_done", int'(done4), 0);
      check("arst_pass", int'(pass4), 0);
      check("arst_err", int'(err4), 0);
      check("arst_scnt", int'(scnt4), 0);
      check("arst_ecnt", int'(ecnt4), 0);
      check("arst_fidx", int'(fidx4), 0);
      check("arst_fvec", int'(fvec4), 0);
      tick();
      rst_n = 1'b1;
      tick();
      start4_run(4'b1000);
      for (int j = 0; j < 4; j++) send(runs[0].vecs[11 - 3*j -: 3]);
      check("post_rst_done", int'(done4), 1);
      check("post_rst_scnt", int'(scnt4), 4);
      check("post_rst_ecnt", int'(ecnt4), 0);
      check("post_rst_pass", int'(pass4), 1);

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
